// File: rtl/adder_result_buf.sv
// Result FIFO behind the 64-bit pipelined adder, with in-flight credit tracking (issue_ok).
// Optional sticky error flag and drop counter enabled by `ADDER_RESULT_BUF_ERR_EN.
module adder_result_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue,
  input  logic                  in_en,
  input  logic [DATA_WIDTH:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out_data,
  output logic                  issue_ok,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]     PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [CNT_WIDTH-1:0]  count_r, count_nxt_s;
  logic [CNT_WIDTH-1:0]  inflight_r, inflight_nxt_s;
  logic [CNT_WIDTH:0]    credit_sum_s;
  logic                  full_s, push_s, pop_s;

  // Handshake decode; a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full_s = (count_r == DEPTH_C);
    pop_s  = (count_r != '0) && out_ready;
    push_s = in_en && (!full_s || pop_s);
  end

  // Occupancy next state.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // In-flight next state, saturating at 0 and DEPTH.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({issue, in_en})
      2'b10: begin
        if (inflight_r != DEPTH_C) inflight_nxt_s = inflight_r + CNT_ONE;
        else                       inflight_nxt_s = inflight_r;
      end
      2'b01: begin
        if (inflight_r != '0) inflight_nxt_s = inflight_r - CNT_ONE;
        else                  inflight_nxt_s = inflight_r;
      end
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Storage array and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= in_data;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Occupancy and in-flight counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= '0;
      inflight_r <= '0;
    end else begin
      count_r    <= count_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  // Credit uses registered state only, so issue never races with itself.
  always_comb begin
    credit_sum_s = {1'b0, count_r} + {1'b0, inflight_r};
    issue_ok     = (credit_sum_s < {1'b0, DEPTH_C});
    out_valid    = (count_r != '0);
    out_data     = mem_r[rd_ptr_r];
    level        = count_r;
  end

`ifdef ADDER_RESULT_BUF_ERR_EN
  logic        err_r;
  logic [15:0] drop_cnt_r;
  logic        drop_s, underflow_s, overissue_s;

  // Error event decode.
  always_comb begin
    drop_s      = in_en && full_s && !pop_s;
    underflow_s = in_en && !issue && (inflight_r == '0);
    overissue_s = issue && !in_en && (inflight_r == DEPTH_C);
  end

  // Sticky error flag and saturating debug drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r      <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      err_r <= err_r | drop_s | underflow_s | overissue_s;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'h0001;
    end
  end

  assign ovf_err = err_r;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_adder_result_buf.sv
// Directed bench for adder_result_buf: scoreboard queue filled by the driver,
// drained by a negedge monitor on every accepted output word.
module tb_adder_result_buf;

  localparam int W = 65;
`ifdef ADDER_RESULT_BUF_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         issue, in_en, out_ready;
  logic [W-1:0] in_data;
  logic         out_valid, issue_ok, ovf_err;
  logic [W-1:0] out_data;
  logic [3:0]   level;

  logic [W-1:0] sb [$];
  logic [W-1:0] exp_head;
  int n_checks = 0;
  int n_fail   = 0;

  adder_result_buf dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .in_en(in_en), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .issue_ok(issue_ok), .level(level), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs; p marks a word the DUT is expected to accept.
  task automatic cyc(input logic iss, input logic en, input logic [W-1:0] d,
                     input logic rdy, input logic p);
    issue = iss; in_en = en; in_data = d; out_ready = rdy;
    if (p) sb.push_back(d);
    @(posedge clk); #1;
  endtask

  // Monitor: any accepted head must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL head_unexpected: got %0h expected none", out_data);
      end else begin
        exp_head = sb.pop_front();
        chk("head", out_data, exp_head);
      end
    end
  end

  initial begin
    rst_n = 1'b0; issue = 1'b0; in_en = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_level", level, 4'd0);
    chk("rst_issue_ok", issue_ok, 1'b1);
    chk("rst_ovf", ovf_err, 1'b0);
    chk("rst_data", out_data, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single transaction, 4-cycle adder latency
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_issue_ok", issue_ok, 1'b1);
    chk("t1_valid0", out_valid, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 65'h1_0000_0000_0000_0001, 1'b1, 1'b1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 65'h1_0000_0000_0000_0001);
    chk("t1_level", level, 4'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_valid_gone", out_valid, 1'b0);
    chk("t1_level0", level, 4'd0);

    // Credit limit with out_ready low
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
      if (k == 6) chk("t2_ok_after7", issue_ok, 1'b1);
    end
    chk("t2_ok_after8", issue_ok, 1'b0);
    for (int k = 1; k <= 8; k++) cyc(1'b0, 1'b1, 65'(k), 1'b0, 1'b1);
    chk("t2_level8", level, 4'd8);
    chk("t2_ok_full", issue_ok, 1'b0);
    chk("t2_no_err", ovf_err, 1'b0);
    chk("t2_head", out_data, 65'd1);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t2_level7", level, 4'd7);
    chk("t2_ok_after_pop", issue_ok, 1'b1);
    chk("t2_head2", out_data, 65'd2);

    // Refill, then push and pop together while full (pointers wrap)
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("t3_ok_credit", issue_ok, 1'b0);
    cyc(1'b0, 1'b1, 65'd9, 1'b0, 1'b1);
    chk("t3_level8", level, 4'd8);
    cyc(1'b1, 1'b1, 65'd10, 1'b1, 1'b1);
    chk("t3_level_hold", level, 4'd8);
    chk("t3_head3", out_data, 65'd3);
    chk("t3_no_err", ovf_err, 1'b0);

    // Dropped push while full
    cyc(1'b0, 1'b1, 65'hDEAD, 1'b0, 1'b0);
    chk("t4_level8", level, 4'd8);
    chk("t4_head3", out_data, 65'd3);
    chk("t4_ovf", ovf_err, ERR);
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t4_drained", level, 4'd0);
    chk("t4_valid0", out_valid, 1'b0);
    chk("t4_ovf_sticky", ovf_err, ERR);

    // Asynchronous reset mid-operation
    cyc(1'b1, 1'b1, 65'h55, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ovf", ovf_err, 1'b0);
    chk("t5_rst_level", level, 4'd0);
    chk("t5_rst_valid", out_valid, 1'b0);
    sb.delete();
    issue = 1'b0; in_en = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Sustained throughput: one push and one pop per cycle
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 1'b1, 65'(100 + k), 1'b1, 1'b1);
      chk("t6_level", level, 4'd1);
    end
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_level0", level, 4'd0);
    chk("t6_no_err", ovf_err, 1'b0);

    // Underflow: result with nothing in flight is still stored
    cyc(1'b0, 1'b1, 65'h77, 1'b1, 1'b1);
    chk("t7_level", level, 4'd1);
    chk("t7_data", out_data, 65'h77);
    chk("t7_ovf", ovf_err, ERR);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
      if (k == 6) chk("t7_ok_after7", issue_ok, 1'b1);
    end
    chk("t7_ok_after8", issue_ok, 1'b0);

    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
